// File: rtl/qam_pkg.sv
// Shared definitions for the 16QAM receive front end.
//   QAM_DW                  default I/Q sample width
//   QAM_THR_HI / QAM_THR_LO hard-decision slicer thresholds (used by the demapper)
//   cal_state_t             calibration FSM encoding
//   sat_max / sat_min       saturation bounds of a signed word of a given width
package qam_pkg;

    localparam int QAM_DW     = 8;
    localparam int QAM_THR_HI = 64;
    localparam int QAM_THR_LO = -64;

    typedef enum logic [1:0] {
        CAL_IDLE = 2'd0,
        CAL_CAL  = 2'd1,
        CAL_RUN  = 2'd2
    } cal_state_t;

    function automatic int sat_max(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    function automatic int sat_min(input int dw);
        return -(1 << (dw - 1));
    endfunction

    localparam int QAM_SAT_MAX = sat_max(QAM_DW);
    localparam int QAM_SAT_MIN = sat_min(QAM_DW);

endpackage

// File: rtl/qam_sat_sub.sv
// Combinational signed subtract y = sat(a - b).
// The difference is formed at DW+1 bits and clamped to the DW-bit signed range.
//   a  in  DW  signed minuend (sample)
//   b  in  DW  signed subtrahend (offset)
//   y  out DW  saturated signed difference
module qam_sat_sub
    import qam_pkg::*;
#(
    parameter int DW = QAM_DW
) (
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [DW-1:0] y
);

    localparam logic signed [DW-1:0] MAX_VAL = DW'(sat_max(DW));
    localparam logic signed [DW-1:0] MIN_VAL = DW'(sat_min(DW));

    logic [DW:0] diff;

    assign diff = {a[DW-1], a} - {b[DW-1], b};

    // Overflow exactly when the two top bits of the wide difference disagree;
    // the top bit then gives the direction.
    always_comb begin
        y = diff[DW-1:0];
        if (diff[DW] != diff[DW-1]) begin
            y = diff[DW] ? MIN_VAL : MAX_VAL;
        end
    end

endmodule

// File: rtl/qam_iq_offset_cal.sv
// I/Q DC-offset calibration and correction ahead of the 16QAM slicer.
// CAL averages 2^AVG_LOG2 signal-free samples into offset_I/offset_Q (floor);
// RUN outputs saturated (sample - offset) with one cycle of latency.
// Optional macro QAM_CAL_TIMEOUT_EN: abort CAL after CAL_TIMEOUT cycles
// with a cal_err pulse (otherwise cal_err is constant 0).
//   symbol_clock, rst        clock, synchronous active-high reset
//   en, cal                  run enable, calibration request (level)
//   in_valid, I_in, Q_in     input samples
//   I_out, Q_out, out_valid  corrected samples
//   offset_I, offset_Q       stored offsets
//   cal_busy, cal_done, cal_err  calibration status
module qam_iq_offset_cal
    import qam_pkg::*;
#(
    parameter int DW          = QAM_DW,
    parameter int AVG_LOG2    = 4,
    parameter int CAL_TIMEOUT = 1024
) (
    input  logic                 symbol_clock,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 cal,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] I_in,
    input  logic signed [DW-1:0] Q_in,
    output logic signed [DW-1:0] I_out,
    output logic signed [DW-1:0] Q_out,
    output logic                 out_valid,
    output logic signed [DW-1:0] offset_I,
    output logic signed [DW-1:0] offset_Q,
    output logic                 cal_busy,
    output logic                 cal_done,
    output logic                 cal_err
);

`ifdef QAM_CAL_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int AW = DW + AVG_LOG2;
    localparam int TW = (CAL_TIMEOUT > 2) ? $clog2(CAL_TIMEOUT) : 1;
    localparam logic [AVG_LOG2-1:0] CNT_LAST   = '1;
    localparam logic [TW-1:0]       TIMER_LAST = TW'(CAL_TIMEOUT - 1);

    cal_state_t state_reg, state_next;
    logic signed [AW-1:0] acc_i_reg, acc_i_next, acc_q_reg, acc_q_next;
    logic signed [AW-1:0] sum_i, sum_q;
    logic [AVG_LOG2-1:0]  cnt_reg, cnt_next;
    logic [TW-1:0]        timer_reg, timer_next;
    logic signed [DW-1:0] offset_i_reg, offset_i_next, offset_q_reg, offset_q_next;
    logic signed [DW-1:0] i_out_reg, i_out_next, q_out_reg, q_out_next;
    logic signed [DW-1:0] sat_i, sat_q;
    logic                 out_valid_reg, out_valid_next;
    logic                 cal_done_reg, cal_done_next;
    logic                 cal_err_reg, cal_err_next;
    logic                 completing;

    qam_sat_sub #(.DW(DW)) u_sat_i (.a(I_in), .b(offset_i_reg), .y(sat_i));
    qam_sat_sub #(.DW(DW)) u_sat_q (.a(Q_in), .b(offset_q_reg), .y(sat_q));

    assign sum_i      = acc_i_reg + {{AVG_LOG2{I_in[DW-1]}}, I_in};
    assign sum_q      = acc_q_reg + {{AVG_LOG2{Q_in[DW-1]}}, Q_in};
    assign completing = in_valid && (cnt_reg == CNT_LAST);

    always_ff @(posedge symbol_clock) begin
        if (rst) begin
            state_reg     <= CAL_IDLE;
            acc_i_reg     <= '0;
            acc_q_reg     <= '0;
            cnt_reg       <= '0;
            timer_reg     <= '0;
            offset_i_reg  <= '0;
            offset_q_reg  <= '0;
            i_out_reg     <= '0;
            q_out_reg     <= '0;
            out_valid_reg <= 1'b0;
            cal_done_reg  <= 1'b0;
            cal_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_i_reg     <= acc_i_next;
            acc_q_reg     <= acc_q_next;
            cnt_reg       <= cnt_next;
            timer_reg     <= timer_next;
            offset_i_reg  <= offset_i_next;
            offset_q_reg  <= offset_q_next;
            i_out_reg     <= i_out_next;
            q_out_reg     <= q_out_next;
            out_valid_reg <= out_valid_next;
            cal_done_reg  <= cal_done_next;
            cal_err_reg   <= cal_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        acc_i_next     = acc_i_reg;
        acc_q_next     = acc_q_reg;
        cnt_next       = cnt_reg;
        timer_next     = timer_reg;
        offset_i_next  = offset_i_reg;
        offset_q_next  = offset_q_reg;
        i_out_next     = i_out_reg;
        q_out_next     = q_out_reg;
        out_valid_next = 1'b0;
        cal_done_next  = 1'b0;
        cal_err_next   = 1'b0;

        case (state_reg)
            CAL_IDLE: begin
                if (cal) begin
                    state_next = CAL_CAL;
                    acc_i_next = '0;
                    acc_q_next = '0;
                    cnt_next   = '0;
                    timer_next = '0;
                end else if (en) begin
                    state_next = CAL_RUN;
                end
            end
            CAL_CAL: begin
                timer_next = timer_reg + 1'b1;
                if (completing) begin
                    // Arithmetic shift of the full sum gives the floored mean.
                    offset_i_next = DW'(sum_i >>> AVG_LOG2);
                    offset_q_next = DW'(sum_q >>> AVG_LOG2);
                    cal_done_next = 1'b1;
                    state_next    = en ? CAL_RUN : CAL_IDLE;
                end else begin
                    if (in_valid) begin
                        acc_i_next = sum_i;
                        acc_q_next = sum_q;
                        cnt_next   = cnt_reg + 1'b1;
                    end
                    // A completing sample on the timeout cycle takes precedence.
                    if (TIMEOUT_EN && (timer_reg == TIMER_LAST)) begin
                        cal_err_next = 1'b1;
                        state_next   = CAL_IDLE;
                    end
                end
            end
            CAL_RUN: begin
                if (cal) begin
                    // The sample presented with the request is dropped.
                    state_next = CAL_CAL;
                    acc_i_next = '0;
                    acc_q_next = '0;
                    cnt_next   = '0;
                    timer_next = '0;
                end else begin
                    if (in_valid) begin
                        i_out_next     = sat_i;
                        q_out_next     = sat_q;
                        out_valid_next = 1'b1;
                    end
                    if (!en) begin
                        state_next = CAL_IDLE;
                    end
                end
            end
            default: state_next = CAL_IDLE;
        endcase
    end

    assign I_out     = i_out_reg;
    assign Q_out     = q_out_reg;
    assign out_valid = out_valid_reg;
    assign offset_I  = offset_i_reg;
    assign offset_Q  = offset_q_reg;
    assign cal_busy  = (state_reg == CAL_CAL);
    assign cal_done  = cal_done_reg;
    assign cal_err   = cal_err_reg;

endmodule

// File: tb/tb_qam_iq_offset_cal.sv
// Self-checking bench for qam_iq_offset_cal: table-driven RUN vectors plus
// hand-written calibration, flooring, saturation, gap, abort and timeout sequences.
module tb_qam_iq_offset_cal;

    logic              symbol_clock = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              cal = 1'b0;
    logic              in_valid = 1'b0;
    logic signed [7:0] I_in = '0;
    logic signed [7:0] Q_in = '0;
    logic signed [7:0] I_out, Q_out, offset_I, offset_Q;
    logic              out_valid, cal_busy, cal_done, cal_err;

    int tests = 0;
    int fails = 0;
    int cal_i [16];
    int cal_q [16];

    typedef struct {
        int i_in;
        int q_in;
        int exp_i;
        int exp_q;
    } vec_t;
    vec_t vecs [5];

    qam_iq_offset_cal #(.DW(8), .AVG_LOG2(4), .CAL_TIMEOUT(32)) dut (
        .symbol_clock(symbol_clock), .rst(rst), .en(en), .cal(cal),
        .in_valid(in_valid), .I_in(I_in), .Q_in(Q_in),
        .I_out(I_out), .Q_out(Q_out), .out_valid(out_valid),
        .offset_I(offset_I), .offset_Q(offset_Q),
        .cal_busy(cal_busy), .cal_done(cal_done), .cal_err(cal_err)
    );

    always #5 symbol_clock = ~symbol_clock;

    task automatic tick();
        @(posedge symbol_clock);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end else begin
            $display("ok   %s: %0d", nm, act);
        end
    endtask

    // Enter CAL, feed cal_i/cal_q, optionally with idle gaps (en toggled during
    // them) and a repeated cal request; expect exactly one cal_done pulse.
    task automatic do_cal(input string nm, input bit gaps, input bit recal,
                          input bit en_after, input int exp_oi, input int exp_oq);
        int dones;
        dones = 0;
        cal = 1'b1; en = en_after; in_valid = 1'b0;
        tick();
        cal = 1'b0;
        check({nm, "_busy"}, int'(cal_busy), 1);
        for (int k = 0; k < 16; k++) begin
            if (gaps && (k % 2 == 1)) begin
                in_valid = 1'b0; en = ~en_after;
                tick();
                dones += int'(cal_done);
            end
            in_valid = 1'b1; en = en_after;
            I_in = 8'(cal_i[k]); Q_in = 8'(cal_q[k]);
            cal = recal && (k == 5);
            tick();
            if (k == 15) check({nm, "_done_pulse"}, int'(cal_done), 1);
            dones += int'(cal_done);
        end
        in_valid = 1'b0; cal = 1'b0;
        tick();
        dones += int'(cal_done);
        check({nm, "_done_count"}, dones, 1);
        check({nm, "_offset_I"}, int'(offset_I), exp_oi);
        check({nm, "_offset_Q"}, int'(offset_Q), exp_oq);
        check({nm, "_busy_after"}, int'(cal_busy), 0);
    endtask

    task automatic run_vec(input string nm, input int i, input int q,
                           input int ei, input int eq);
        in_valid = 1'b1; I_in = 8'(i); Q_in = 8'(q);
        tick();
        check({nm, "_I"}, int'(I_out), ei);
        check({nm, "_Q"}, int'(Q_out), eq);
        check({nm, "_valid"}, int'(out_valid), 1);
    endtask

    initial begin
        int err_cnt, err_at, done_cnt;

        // RUN vectors with offsets I=6, Q=-3
        vecs[0] = '{70, 10, 64, 13};
        vecs[1] = '{-128, 127, -128, 127};
        vecs[2] = '{0, 0, -6, 3};
        vecs[3] = '{127, -128, 121, -125};
        vecs[4] = '{-123, 124, -128, 127};

        // Reset with busy inputs
        rst = 1'b1; en = 1'b1; in_valid = 1'b1; I_in = 8'sd5; Q_in = 8'sd5;
        tick(); tick();
        check("rst_I_out", int'(I_out), 0);
        check("rst_Q_out", int'(Q_out), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_offset_I", int'(offset_I), 0);
        check("rst_offset_Q", int'(offset_Q), 0);
        check("rst_busy", int'(cal_busy), 0);
        check("rst_done", int'(cal_done), 0);
        check("rst_err", int'(cal_err), 0);
        rst = 1'b0; en = 1'b0;
        tick(); tick(); tick();
        check("idle_no_valid", int'(out_valid), 0);
        in_valid = 1'b0;

        // Basic calibration, then table-driven RUN vectors
        for (int k = 0; k < 16; k++) begin cal_i[k] = 6; cal_q[k] = -3; end
        do_cal("cal1", 1'b0, 1'b0, 1'b1, 6, -3);
        for (int v = 0; v < 5; v++) begin
            run_vec($sformatf("vec%0d", v), vecs[v].i_in, vecs[v].q_in,
                    vecs[v].exp_i, vecs[v].exp_q);
        end
        in_valid = 1'b0;
        tick();
        check("gap_valid", int'(out_valid), 0);
        check("gap_hold_I", int'(I_out), -128);

        // Drop en in RUN -> IDLE, offsets kept, no output
        en = 1'b0;
        tick();
        in_valid = 1'b1; I_in = 8'sd50; Q_in = 8'sd50;
        tick();
        check("en_drop_valid", int'(out_valid), 0);
        check("en_drop_hold_I", int'(I_out), -128);
        check("en_drop_off_I", int'(offset_I), 6);
        check("en_drop_off_Q", int'(offset_Q), -3);
        in_valid = 1'b0;

        // Flooring (sum -1 -> -1, sum 0 -> 0) with gaps and a mid-CAL cal pulse
        for (int k = 0; k < 16; k++) begin
            cal_i[k] = (k == 15) ? -1 : 0;
            cal_q[k] = (k % 2 == 0) ? 1 : -1;
        end
        do_cal("floor", 1'b1, 1'b1, 1'b0, -1, 0);
        check("floor_idle_valid", int'(out_valid), 0);

        // Saturation with offsets I=10, Q=-10
        for (int k = 0; k < 16; k++) begin cal_i[k] = 10; cal_q[k] = -10; end
        do_cal("sat", 1'b0, 1'b0, 1'b1, 10, -10);
        run_vec("sat_a", -128, 127, -128, 127);
        run_vec("sat_b", 127, -128, 117, -118);

        // cal in RUN with a sample in the same cycle: sample dropped
        in_valid = 1'b1; I_in = 8'sd0; Q_in = 8'sd0; cal = 1'b1;
        tick();
        cal = 1'b0; in_valid = 1'b0; en = 1'b0;
        check("run_cal_drop_valid", int'(out_valid), 0);
        check("run_cal_busy", int'(cal_busy), 1);

        // Only 5 samples after this entry; wait 40 cycles for a timeout
        err_cnt = 0; err_at = -1;
        for (int c = 1; c <= 40; c++) begin
            in_valid = (c <= 5); I_in = 8'sd100; Q_in = -8'sd100;
            tick();
            if (cal_err) begin err_cnt++; err_at = c; end
        end
        in_valid = 1'b0;
`ifdef QAM_CAL_TIMEOUT_EN
        check("timeout_err_count", err_cnt, 1);
        check("timeout_err_cycle", err_at, 32);
        check("timeout_busy", int'(cal_busy), 0);
`else
        check("no_timeout_err_count", err_cnt, 0);
        check("no_timeout_busy", int'(cal_busy), 1);
`endif
        check("timeout_off_I", int'(offset_I), 10);
        check("timeout_off_Q", int'(offset_Q), -10);
        check("timeout_done", int'(cal_done), 0);

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();

        // rst at sample 8 of a fresh calibration
        for (int k = 0; k < 16; k++) begin cal_i[k] = 20; cal_q[k] = 20; end
        cal = 1'b1; tick(); cal = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; I_in = 8'sd20; Q_in = 8'sd20;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_off_I", int'(offset_I), 0);
        check("abort_off_Q", int'(offset_Q), 0);
        check("abort_busy", int'(cal_busy), 0);
        done_cnt = int'(cal_done);
        for (int c = 0; c < 20; c++) begin
            tick();
            done_cnt += int'(cal_done);
        end
        in_valid = 1'b0;
        check("abort_no_done", done_cnt, 0);
        check("abort_idle_valid", int'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/qam_iq_offset_cal.md
Name: qam_iq_offset_cal

Overview:
- Front-end stage ahead of the 16QAM hard-decision demapper, clocked by symbol_clock.
- During calibration it averages 2^AVG_LOG2 I/Q samples taken with no signal present. The averages become the DC offsets.
- In run mode it subtracts the stored offsets from every sample and saturates the result. The corrected, origin-centred I/Q then goes to the demapper slicer, so the slicer thresholds (0, ±64) sit on the true constellation.

Parameters:
- DW, 8, I/Q sample width (signed two's complement).
- AVG_LOG2, 4, log2 of the number of samples averaged per calibration (16).
- CAL_TIMEOUT, 1024, symbol_clock cycles allowed in CAL before abort (used only with the optional feature).

Ports:
- symbol_clock  in  1  sample clock; all logic is on its rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable
- cal  in  1  calibration request (level, sampled each cycle)
- in_valid  in  1  I_in/Q_in carry a sample this cycle
- I_in  in  DW  signed in-phase sample
- Q_in  in  DW  signed quadrature sample
- I_out  out  DW  signed corrected in-phase sample
- Q_out  out  DW  signed corrected quadrature sample
- out_valid  out  1  I_out/Q_out valid (single-cycle per sample)
- offset_I  out  DW  stored in-phase offset
- offset_Q  out  DW  stored quadrature offset
- cal_busy  out  1  high while in CAL
- cal_done  out  1  one-cycle pulse when new offsets are latched
- cal_err  out  1  one-cycle pulse on calibration timeout

Behaviour:
- Reset (synchronous, active-high; reset is rst, clock is symbol_clock):
  - state=IDLE.
  - All outputs 0; offsets 0, accumulators 0, counter 0.
  - rst during CAL aborts the calibration. Offsets return to 0. No cal_done.
- States:
  - IDLE: out_valid=0.
    - cal=1 -> CAL (cal has priority over en).
    - else en=1 -> RUN.
  - CAL:
    - On entry: acc_I, acc_Q and cnt are cleared to 0.
    - Each in_valid cycle: acc += sign-extended sample; cnt++.
    - Accumulator width is DW+AVG_LOG2, so no overflow is possible.
    - Completing sample (in_valid with cnt == 2^AVG_LOG2-1):
      - offset = (acc + sample) >>> AVG_LOG2, arithmetic shift (floor).
      - cal_done=1 for the next cycle.
      - Next state: RUN if en, else IDLE.
    - cal re-asserted while in CAL is ignored (no restart).
    - en changes during CAL are ignored until completion.
    - out_valid=0 throughout CAL; cal_busy=1.
  - RUN:
    - Each in_valid cycle: compute in_valid sample − offset at DW+1 bits, then saturate to [-2^(DW-1), 2^(DW-1)-1].
    - The result registers to I_out/Q_out. out_valid=1 on the following cycle (latency 1).
    - When in_valid=0, out_valid=0 and I_out/Q_out hold their last value.
    - cal=1 -> CAL. A sample presented in that same cycle is not output.
    - else en=0 -> IDLE. Offsets retained.
- Offsets change only on calibration completion or reset.
- cal_done and cal_err never assert in the same cycle.

Optional Feature:
- Macro: QAM_CAL_TIMEOUT_EN.
- Defined:
  - A cycle counter runs while in CAL.
  - If it reaches CAL_TIMEOUT-1 before the completing sample: the calibration aborts and the state goes to IDLE.
  - Previous offsets are retained and cal_err pulses for one cycle.
  - A completing sample on the timeout cycle wins: cal_done, no cal_err.
- Undefined:
  - No timer; CAL waits indefinitely.
  - cal_err is tied to 0 and the port remains present.

Decomposition:
- Shared package qam_pkg holds:
  - QAM_DW=8.
  - Slicer thresholds QAM_THR_HI=64, QAM_THR_LO=-64.
  - State encoding: CAL_IDLE=2'd0, CAL_CAL=2'd1, CAL_RUN=2'd2.
  - Saturation bounds derived from DW.
- Sub-module qam_sat_sub: combinational DW-bit signed subtract with saturation. Instantiated twice, for I and for Q.

Test Plan:
- Reset check: rst high 2 cycles -> all outputs 0, state IDLE. rst released with en=0 -> out_valid stays 0.
- Calibration: cal=1, 16 valid samples of I=+6, Q=-3 -> cal_done pulses one cycle after the 16th; offset_I=6, offset_Q=-3. Then run I_in=70, Q_in=10 -> I_out=64, Q_out=13, out_valid one cycle later.
- Flooring: samples 15×I=0 plus 1×I=-1 (sum -1) -> offset_I=-1. Samples alternating ±1 (sum 0) -> offset 0.
- Saturation: offsets I=+10, Q=-10; inputs I=-128, Q=127 -> I_out=-128, Q_out=127.
- Gaps and control: in_valid toggled 1-0-1 during CAL -> only valid samples are counted. cal pulsed mid-CAL -> no restart, one cal_done. en dropped in RUN -> IDLE, offsets unchanged.
- Abort cases: rst at sample 8 of CAL -> offsets 0, no cal_done. With QAM_CAL_TIMEOUT_EN, CAL_TIMEOUT=32 and only 5 samples supplied -> cal_err pulses at cycle 32, old offsets retained.
